// File: rtl/pattern_edge_writer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_edge_writer
// Description : Converts one closed-polygon vertex stream into MAX_EDGES edge
//               records and writes them into a pattern RAM slot, one per clk.
// Revision    : 1.0
// ============================================================================
module pattern_edge_writer #(
    parameter int MAX_EDGES = 30,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        pattern_num,
    input  logic              vtx_valid,
    output logic              vtx_ready,
    input  logic [9:0]        vtx_x,
    input  logic [8:0]        vtx_y,
    input  logic              vtx_last,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_Addr,
    output logic [37:0]       w_Data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int KW = $clog2(MAX_EDGES + 1);
    localparam logic [KW-1:0]     c_MAX    = KW'(MAX_EDGES);
    localparam logic [KW-1:0]     c_LAST_K = KW'(MAX_EDGES - 1);
    localparam logic [KW-1:0]     c_MIN_V  = KW'(3);
    localparam logic [ADDR_W-1:0] c_SLOT   = ADDR_W'(MAX_EDGES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_EDGE  = 3'd2,
        S_CLOSE = 3'd3,
        S_PAD   = 3'd4,
        S_DRAIN = 3'd5,
        S_ERR   = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [KW-1:0]      r_k, w_k_nxt;
    logic [KW-1:0]      r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]  r_base, w_base_nxt;
    logic [9:0]         r_first_x, w_first_x_nxt, r_prev_x, w_prev_x_nxt;
    logic [8:0]         r_first_y, w_first_y_nxt, r_prev_y, w_prev_y_nxt;
    logic               r_vtx_ready, w_vtx_ready_nxt;
    logic               r_w_en, w_w_en_nxt;
    logic [ADDR_W-1:0]  r_w_addr, w_w_addr_nxt;
    logic [37:0]        r_w_data, w_w_data_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic               w_hs;
    logic [KW-1:0]      w_cnt_inc;
    logic [ADDR_W-1:0]  w_slot_addr;

    assign w_hs        = vtx_valid & r_vtx_ready;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_slot_addr = r_base + ADDR_W'(r_k);

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_cnt_nxt     = r_cnt;
        w_base_nxt    = r_base;
        w_first_x_nxt = r_first_x;
        w_first_y_nxt = r_first_y;
        w_prev_x_nxt  = r_prev_x;
        w_prev_y_nxt  = r_prev_y;
        w_w_en_nxt    = 1'b0;
        w_w_addr_nxt  = r_w_addr;
        w_w_data_nxt  = r_w_data;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt  = ADDR_W'(pattern_num) * c_SLOT;
                    w_k_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_FIRST;
                end
            end
            S_FIRST: begin
                if (w_hs) begin
                    w_first_x_nxt = vtx_x;
                    w_first_y_nxt = vtx_y;
                    w_prev_x_nxt  = vtx_x;
                    w_prev_y_nxt  = vtx_y;
                    w_cnt_nxt     = KW'(1);
                    w_state_nxt   = vtx_last ? S_ERR : S_EDGE;
                end
            end
            S_EDGE: begin
                if (w_hs) begin
                    w_w_en_nxt   = 1'b1;
                    w_w_addr_nxt = w_slot_addr;
                    w_w_data_nxt = {r_prev_x, r_prev_y, vtx_x, vtx_y};
                    w_k_nxt      = r_k + 1'b1;
                    w_prev_x_nxt = vtx_x;
                    w_prev_y_nxt = vtx_y;
                    w_cnt_nxt    = w_cnt_inc;
                    if (vtx_last) begin
                        w_state_nxt = (w_cnt_inc >= c_MIN_V) ? S_CLOSE : S_ERR;
                    end else if (w_cnt_inc == c_MAX) begin
                        // Slot is full of chained edges; no room left for the close edge.
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_CLOSE: begin
                w_w_en_nxt   = 1'b1;
                w_w_addr_nxt = w_slot_addr;
                w_w_data_nxt = {r_prev_x, r_prev_y, r_first_x, r_first_y};
                w_k_nxt      = r_k + 1'b1;
                w_state_nxt  = (r_k == c_LAST_K) ? S_FIN : S_PAD;
            end
            S_PAD: begin
                // Zero record is horizontal (y0==y1), so it never registers a crossing.
                w_w_en_nxt   = 1'b1;
                w_w_addr_nxt = w_slot_addr;
                w_w_data_nxt = '0;
                w_k_nxt      = r_k + 1'b1;
                if (r_k == c_LAST_K) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_DRAIN: begin
                if (w_hs && vtx_last) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                w_err_nxt   = 1'b1;
                w_k_nxt     = '0;
                w_state_nxt = S_PAD;
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_vtx_ready_nxt = (w_state_nxt == S_FIRST) || (w_state_nxt == S_EDGE) ||
                          (w_state_nxt == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_base      <= '0;
            r_first_x   <= '0;
            r_first_y   <= '0;
            r_prev_x    <= '0;
            r_prev_y    <= '0;
            r_vtx_ready <= 1'b0;
            r_w_en      <= 1'b0;
            r_w_addr    <= '0;
            r_w_data    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_cnt       <= w_cnt_nxt;
            r_base      <= w_base_nxt;
            r_first_x   <= w_first_x_nxt;
            r_first_y   <= w_first_y_nxt;
            r_prev_x    <= w_prev_x_nxt;
            r_prev_y    <= w_prev_y_nxt;
            r_vtx_ready <= w_vtx_ready_nxt;
            r_w_en      <= w_w_en_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_w_data    <= w_w_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign vtx_ready = r_vtx_ready;
    assign w_en      = r_w_en;
    assign w_Addr    = r_w_addr;
    assign w_Data    = r_w_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pattern_edge_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_edge_writer
// Description : Scoreboard bench for pattern_edge_writer (write stream, RAM image,
//               err/done/busy and latency).
// Revision    : 1.0
// ============================================================================
module tb_pattern_edge_writer;

    localparam int ME = 30;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    pattern_num;
    logic          vtx_valid;
    logic          vtx_ready;
    logic [9:0]    vtx_x;
    logic [8:0]    vtx_y;
    logic          vtx_last;
    logic          w_en;
    logic [AW-1:0] w_Addr;
    logic [37:0]   w_Data;
    logic          busy;
    logic          done;
    logic          err;

    pattern_edge_writer #(.MAX_EDGES(ME), .ADDR_W(AW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern_num (pattern_num),
        .vtx_valid   (vtx_valid),
        .vtx_ready   (vtx_ready),
        .vtx_x       (vtx_x),
        .vtx_y       (vtx_y),
        .vtx_last    (vtx_last),
        .w_en        (w_en),
        .w_Addr      (w_Addr),
        .w_Data      (w_Data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [37:0]   d;
    } wr_t;

    wr_t         sb[$];
    logic [37:0] ram [0:255];
    int          n_chk    = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          vx [0:40];
    int          vy [0:40];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [37:0] mk(input int x0, input int y0, input int x1, input int y1);
        return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
    endfunction

    // Expected write order: chained edges as vertices arrive, then close+pads or an all-zero rewrite.
    task automatic push_exp(input int n, input int pn);
        int  base, k, nch;
        bit  ok;
        wr_t e;
        base = pn * ME;
        k    = 0;
        nch  = (n < ME) ? n : ME;
        ok   = (n >= 3) && (n <= ME);
        for (int i = 1; i < nch; i++) begin
            e.a = AW'(base + k);
            e.d = mk(vx[i-1], vy[i-1], vx[i], vy[i]);
            sb.push_back(e);
            k++;
        end
        if (ok) begin
            e.a = AW'(base + k);
            e.d = mk(vx[n-1], vy[n-1], vx[0], vy[0]);
            sb.push_back(e);
            k++;
        end else begin
            k = 0;
        end
        for (int j = k; j < ME; j++) begin
            e.a = AW'(base + j);
            e.d = '0;
            sb.push_back(e);
        end
    endtask

    task automatic check_image(input int n, input int pn);
        bit          ok;
        logic [37:0] exp;
        ok = (n >= 3) && (n <= ME);
        for (int j = 0; j < ME; j++) begin
            exp = '0;
            if (ok && j < n) exp = mk(vx[j], vy[j], vx[(j+1)%n], vy[(j+1)%n]);
            chk("img", 64'(ram[pn*ME+j]), 64'(exp));
        end
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (w_en) begin
                ram[w_Addr] = w_Data;
                if (sb.size() == 0) begin
                    chk("wr_extra", 64'(w_en), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 64'(w_Addr), 64'(e.a));
                    chk("wr_data", 64'(w_Data), 64'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_poly(input int n, input int pn, input bit bubbles,
                            input bit extra_start, input bit abort, input int lat_exp);
        int i, g, d0, t_last;
        bit ok;
        ok = (n >= 3) && (n <= ME);
        push_exp(n, pn);
        d0 = done_cnt;
        @(negedge clk);
        start       = 1'b1;
        pattern_num = 3'(pn);
        @(negedge clk);
        start = 1'b0;
        chk("busy_set", 64'(busy), 64'd1);
        i = 0; g = 0; t_last = 0;
        while (i < n && g < 4000) begin
            start = extra_start && (g == 3);
            if (start) pattern_num = 3'd5;
            if (bubbles && (g % 2 == 1)) begin
                vtx_valid = 1'b0;
            end else begin
                vtx_valid = 1'b1;
                vtx_x     = 10'(vx[i]);
                vtx_y     = 9'(vy[i]);
                vtx_last  = (i == n - 1);
            end
            if (vtx_valid && vtx_ready) begin
                if (i == n - 1) t_last = cyc;
                i++;
            end
            g++;
            @(negedge clk);
        end
        vtx_valid = 1'b0;
        vtx_last  = 1'b0;
        start     = 1'b0;
        if (i < n) chk("vtx_timeout", 64'(i), 64'(n));
        if (abort) begin
            repeat (6) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_wen",   64'(w_en),      64'd0);
            chk("abort_busy",  64'(busy),      64'd0);
            chk("abort_done",  64'(done),      64'd0);
            chk("abort_ready", 64'(vtx_ready), 64'd0);
            reset = 1'b0;
            sb.delete();
            repeat (2) @(negedge clk);
            chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        end else begin
            g = 0;
            while (done_cnt == d0 && g < 200) begin
                @(negedge clk);
                g++;
            end
            repeat (4) @(negedge clk);
            chk("done_once", 64'(done_cnt - d0), 64'd1);
            if (lat_exp >= 0) chk("done_latency", 64'(done_cyc - t_last), 64'(lat_exp));
            chk("err",      64'(err),       64'(!ok));
            chk("busy_clr", 64'(busy),      64'd0);
            chk("sb_empty", 64'(sb.size()), 64'd0);
            check_image(n, pn);
        end
    endtask

    task automatic set_tri();
        vx[0] = 0;   vy[0] = 0;
        vx[1] = 100; vy[1] = 0;
        vx[2] = 50;  vy[2] = 80;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        reset       = 1'b1;
        start       = 1'b0;
        pattern_num = '0;
        vtx_valid   = 1'b0;
        vtx_x       = '0;
        vtx_y       = '0;
        vtx_last    = 1'b0;
        for (int a = 0; a < 256; a++) ram[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(vtx_ready), 64'd0);
        chk("rst_wen",   64'(w_en),      64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(err),       64'd0);
        chk("rst_addr",  64'(w_Addr),    64'd0);
        chk("rst_data",  64'(w_Data),    64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: triangle into slot 2
        set_tri();
        run_poly(3, 2, 1'b0, 1'b0, 1'b0, 30);

        // 2: 30-vertex polygon fills slot 7 with no padding
        for (int i = 0; i < 30; i++) begin
            vx[i] = i * 21;
            vy[i] = (i * 37) % 480;
        end
        run_poly(30, 7, 1'b0, 1'b0, 1'b0, 3);

        // 3: 31 vertices overflow slot 0
        for (int i = 0; i < 31; i++) begin
            vx[i] = i * 20;
            vy[i] = i * 15;
        end
        run_poly(31, 0, 1'b0, 1'b0, 1'b0, -1);

        // 4: too few vertices into slot 1
        vx[0] = 10; vy[0] = 10;
        vx[1] = 20; vy[1] = 20;
        run_poly(2, 1, 1'b0, 1'b0, 1'b0, -1);

        // 5: triangle again with input bubbles and a stray start while busy
        set_tri();
        run_poly(3, 2, 1'b1, 1'b1, 1'b0, 30);

        // 6: reset during padding, then a normal square load
        set_tri();
        run_poly(3, 3, 1'b0, 1'b0, 1'b1, -1);
        vx[0] = 100; vy[0] = 100;
        vx[1] = 200; vy[1] = 100;
        vx[2] = 200; vy[2] = 200;
        vx[3] = 100; vy[3] = 200;
        run_poly(4, 4, 1'b0, 1'b0, 1'b0, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
